// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store sequencer between the
// EX/MEM pipeline slot and a req/gnt + rvalid data-memory port.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses are
// trapped (done+err, no request) instead of being silently aligned.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_val,
  input  logic        mem_rw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;

  logic          accept, bad, trap, last;
  logic [1:0]    off_c;
  logic [3:0]    be_c;
  logic [31:0]   wd_c;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   fmt;
  logic          take, n_done, n_err, n_wbv;

  // A new access is only taken when the previous one is not finishing this cycle.
  assign accept = ex_valid & mem_val & ~done;
  assign stall  = accept;
  assign last   = (cnt == CW'(TIMEOUT - 1));

  assign dmem_req = (state == REQ);
  assign dmem_we  = dmem_req & we_q;

  // Decode legality, effective byte offset, byte enables and replicated store data.
  always_comb begin
    bad   = 1'b0;
    off_c = 2'b00;
    be_c  = 4'b1111;
    wd_c  = wdata;
    case (funct3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = mem_rw;
      default:                bad = 1'b1;
    endcase
    case (funct3[1:0])
      2'b00: begin
        off_c = addr[1:0];
        be_c  = 4'b0001 << addr[1:0];
        wd_c  = {4{wdata[7:0]}};
      end
      2'b01: begin
        // low address bit dropped: halfwords always land on an even lane
        off_c = {addr[1], 1'b0};
        be_c  = 4'b0011 << {addr[1], 1'b0};
        wd_c  = {2{wdata[15:0]}};
      end
      default: begin
        off_c = 2'b00;
        be_c  = 4'b1111;
        wd_c  = wdata;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned halfword/word accesses are refused rather than aligned.
  assign trap = ((funct3[1:0] == 2'b01) & addr[0]) |
                ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  // Select the addressed lane from the read word and extend it to 32 bits.
  always_comb begin
    lane_b = dmem_rdata[7:0];
    case (off_q)
      2'd0: lane_b = dmem_rdata[7:0];
      2'd1: lane_b = dmem_rdata[15:8];
      2'd2: lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  fmt = {24'd0, lane_b};
      3'b101:  fmt = {16'd0, lane_h};
      default: fmt = dmem_rdata;
    endcase
  end

  // Next-state and completion decode; store grant beats timeout, which beats load grant.
  always_comb begin
    nstate = state;
    take   = 1'b0;
    n_done = 1'b0;
    n_err  = 1'b0;
    n_wbv  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad | trap) begin
            n_done = 1'b1;
            n_err  = 1'b1;
          end else begin
            nstate = REQ;
            take   = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_gnt & we_q) begin
          nstate = IDLE;
          n_done = 1'b1;
        end else if (last) begin
          nstate = IDLE;
          n_done = 1'b1;
          n_err  = 1'b1;
        end else if (dmem_gnt) begin
          nstate = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          nstate = IDLE;
          n_done = 1'b1;
          n_wbv  = 1'b1;
        end else if (last) begin
          nstate = IDLE;
          n_done = 1'b1;
          n_err  = 1'b1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State register and the REQ/WAIT cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      if (take)
        cnt <= '0;
      else if (state != IDLE)
        cnt <= cnt + 1'b1;
    end
  end

  // Capture the access on accept; request fields stay stable until it ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
    end else if (take) begin
      dmem_addr  <= {addr[31:2], 2'b00};
      dmem_wdata <= wd_c;
      dmem_be    <= be_c;
      we_q       <= mem_rw;
      f3_q       <= funct3;
      off_q      <= off_c;
      rd_q       <= rd_in;
    end
  end

  // Registered completion pulses and load writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      err      <= 1'b0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
    end else begin
      done     <= n_done;
      err      <= n_err;
      wb_valid <= n_wbv;
      if (n_wbv) begin
        wb_data <= fmt;
        wb_rd   <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit. Expected timing is
// computed in closed form from grant/response delays; expected data from
// plain arithmetic on address offset and access size.
module tb_mem_access_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_val, mem_rw;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        stall, done, wb_valid, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_chk = 0;
  int n_err = 0;

  mem_access_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_val(mem_val),
    .mem_rw(mem_rw), .funct3(funct3), .addr(addr), .wdata(wdata), .rd_in(rd_in),
    .stall(stall), .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   {31'd0, dmem_req}, 0);
    chk({tag, "_we"},    {31'd0, dmem_we}, 0);
    chk({tag, "_done"},  {31'd0, done}, 0);
    chk({tag, "_wbv"},   {31'd0, wb_valid}, 0);
    chk({tag, "_err"},   {31'd0, err}, 0);
    chk({tag, "_be"},    {28'd0, dmem_be}, 0);
    chk({tag, "_addr"},  dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wbdat"}, wb_data, 0);
    chk({tag, "_wbrd"},  {27'd0, wb_rd}, 0);
  endtask

  // One access: g = REQ cycles before grant, r = WAIT cycles before rvalid.
  task automatic run_access(input bit rw, input bit [2:0] f3, input bit [31:0] a,
                            input bit [31:0] wd, input bit [4:0] rd, input bit [31:0] rdat,
                            input int g, input int r, input bit drop);
    bit        bad, e_err, e_wbv;
    bit [1:0]  sz, off;
    bit [31:0] e_be, e_wd, e_wb, lane;
    int        done_c, req_last;

    bad = !((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!rw && ((f3 == 3'd4) || (f3 == 3'd5))));
`ifdef MISALIGN_TRAP_EN
    if (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00)) bad = 1;
`endif
    sz   = f3[1:0];
    off  = (sz == 2'd0) ? a[1:0] : (sz == 2'd1) ? {a[1], 1'b0} : 2'd0;
    e_be = (sz == 2'd0) ? (32'd1 << off) : (sz == 2'd1) ? (32'd3 << off) : 32'hF;
    e_wd = (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    lane = rdat >> (8 * off);
    case (f3)
      3'd0:    e_wb = lane[7]  ? ((lane & 32'hFF) | 32'hFFFF_FF00) : (lane & 32'hFF);
      3'd1:    e_wb = lane[15] ? ((lane & 32'hFFFF) | 32'hFFFF_0000) : (lane & 32'hFFFF);
      3'd4:    e_wb = lane & 32'hFF;
      3'd5:    e_wb = lane & 32'hFFFF;
      default: e_wb = rdat;
    endcase

    e_wbv = 0;
    if (bad) begin
      done_c = 1; e_err = 1; req_last = 0;
    end else begin
      req_last = (g + 1 <= T) ? g + 1 : T;
      if (rw) begin
        if (g + 1 <= T) begin done_c = g + 2; e_err = 0; end
        else begin done_c = T + 1; e_err = 1; end
      end else begin
        if (g + r + 2 <= T) begin done_c = g + r + 3; e_err = 0; e_wbv = 1; end
        else begin done_c = T + 1; e_err = 1; end
      end
    end

    @(negedge clk);
    chk("idle_done", {31'd0, done}, 0);
    chk("idle_req", {31'd0, dmem_req}, 0);
    ex_valid = 1; mem_val = 1; mem_rw = rw; funct3 = f3; addr = a;
    wdata = wd; rd_in = rd; dmem_gnt = 0; dmem_rvalid = 0;
    #1 chk("stall0", {31'd0, stall}, 1);

    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      chk("done", {31'd0, done}, (c == done_c) ? 1 : 0);
      chk("err", {31'd0, err}, (c == done_c && e_err) ? 1 : 0);
      chk("wb_valid", {31'd0, wb_valid}, (c == done_c && e_wbv) ? 1 : 0);
      if (c == done_c && e_wbv) begin
        chk("wb_data", wb_data, e_wb);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      end
      chk("req", {31'd0, dmem_req}, (c <= req_last) ? 1 : 0);
      if (c <= req_last) begin
        chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
        chk("dmem_be", {28'd0, dmem_be}, e_be);
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, rw});
        if (rw) chk("dmem_wdata", dmem_wdata, e_wd);
      end
      chk("stall", {31'd0, stall}, (ex_valid && mem_val && c != done_c) ? 1 : 0);
      if (c == done_c) begin
        ex_valid = 0; mem_val = 0; dmem_gnt = 0; dmem_rvalid = 0;
      end else begin
        if (drop && c == 1) ex_valid = 0;
        dmem_gnt = (c == g + 1) ? 1'b1 : (c > g + 1) ? 1'($urandom % 2) : 1'b0;
        if (!rw && c == g + 2 + r) begin
          dmem_rvalid = 1; dmem_rdata = rdat;
        end else begin
          dmem_rvalid = (c <= g + 1) ? 1'($urandom % 2) : 1'b0;
          dmem_rdata  = $urandom;
        end
      end
    end
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; mem_val = 0; mem_rw = 0; funct3 = 0;
    addr = 0; wdata = 0; rd_in = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    #2 chk_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1;

    // LB from byte 3, sign bit set
    run_access(0, 3'd0, 32'h103, 0, 5'd7, 32'h80FF_FF12, 0, 0, 0);
    // SH upper half
    run_access(1, 3'd1, 32'h202, 32'h1234_ABCD, 0, 0, 0, 0, 0);
    // LW never granted -> timeout
    run_access(0, 3'd2, 32'h40, 0, 5'd3, 0, 20, 0, 0);
    // LW misaligned
    run_access(0, 3'd2, 32'h301, 0, 5'd9, 32'hDEAD_BEEF, 0, 0, 0);
    // illegal funct3 and unsigned store
    run_access(0, 3'd3, 32'h10, 0, 5'd1, 0, 0, 0, 0);
    run_access(1, 3'd4, 32'h10, 32'h55, 0, 0, 0, 0, 0);
    run_access(1, 3'd7, 32'h10, 32'h55, 0, 0, 0, 0, 0);
    // timeout boundaries
    run_access(1, 3'd2, 32'h80, 32'hCAFE_F00D, 0, 0, T - 1, 0, 0);
    run_access(1, 3'd0, 32'h81, 32'h77, 0, 0, T, 0, 0);
    run_access(0, 3'd1, 32'h86, 0, 5'd4, 32'h7FFF_0001, 0, T - 2, 0);
    run_access(0, 3'd1, 32'h86, 0, 5'd4, 32'h7FFF_0001, 0, T - 1, 0);
    run_access(0, 3'd4, 32'h85, 0, 5'd5, 32'h1234_9A78, T - 1, 0, 0);
    // upstream drops ex_valid mid-access
    run_access(0, 3'd5, 32'h92, 0, 5'd6, 32'hF00D_8765, 2, 1, 1);

    for (int i = 0; i < 60; i++) begin
      int g, r;
      g = ($urandom % 8 == 0) ? $urandom_range(T - 2, T + 4) : $urandom_range(0, 3);
      r = ($urandom % 8 == 0) ? $urandom_range(T - 4, T + 2) : $urandom_range(0, 3);
      run_access(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom,
                 5'($urandom % 32), $urandom, g, r, 1'($urandom % 4 == 0));
    end

    // reset while waiting for read data, then a late rvalid
    @(negedge clk);
    ex_valid = 1; mem_val = 1; mem_rw = 0; funct3 = 3'd2; addr = 32'h44; rd_in = 5'd12;
    @(negedge clk);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    rst_n = 0; ex_valid = 0; mem_val = 0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("late_done", {31'd0, done}, 0);
    chk("late_wbv", {31'd0, wb_valid}, 0);
    chk("late_req", {31'd0, dmem_req}, 0);
    run_access(0, 3'd5, 32'h2, 0, 5'd10, 32'h8001_0000, 0, 0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
